// File: rtl/prbs_pkg.sv
// Shared definitions for the 11-bit XNOR-feedback PRBS generator and checker.
package prbs_pkg;

   localparam int LFSR_LEN = 11;
   localparam int TAP_A    = 0;
   localparam int TAP_B    = 2;

   typedef enum logic {
      SEED   = 1'b0,
      LOCKED = 1'b1
   } prbs_state_e;

   // r[0] is the oldest bit; returns the bit that follows r[LFSR_LEN-1]
   function automatic logic next_bit(input logic [LFSR_LEN-1:0] r);
      return r[TAP_A] ^ ~r[TAP_B];
   endfunction

   function automatic logic is_lockup(input logic [LFSR_LEN-1:0] r);
      return &r;
   endfunction

endpackage

// File: rtl/prbs_checker.sv
// PRBS checker: seeds a shadow register from the received stream, then predicts
// two bits per sample, counts mismatches and drops lock on a run of errors.
module prbs_checker
   import prbs_pkg::*;
#(
   parameter int ERR_W      = 16,
   parameter int LOSS_LIMIT = 4
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             En,
   input  logic [1:0]       Ran,
   input  logic             Clear,
   output logic             Locked,
   output logic             Error,
   output logic             LockLost,
   output logic [ERR_W-1:0] ErrCount
);

   localparam logic [3:0]       SEED_LAST = 4'd10;
   localparam logic [7:0]       LOSS_LIM  = 8'(LOSS_LIMIT);
   localparam logic [ERR_W-1:0] ERR_MAX   = '1;
   localparam logic [ERR_W-1:0] ERR_ONE   = ERR_W'(1);

   prbs_state_e         state_q;
   logic [LFSR_LEN-1:0] shreg_q;
   logic [3:0]          seed_cnt_q;
   logic [7:0]          consec_q;
   logic [ERR_W-1:0]    err_cnt_q;
   logic [ERR_W-1:0]    err_cnt_d;
   logic                locked_q;
   logic                error_q;
   logic                lock_lost_q;

   logic [LFSR_LEN-1:0] seed_shift_s;
   logic [7:0]          consec_inc_s;
   logic                p_s;
   logic                q_s;
   logic                bad_s;

   // q_s predicts one bit further ahead, so the window is shifted by one
   assign p_s          = next_bit(shreg_q);
   assign q_s          = next_bit({1'b0, shreg_q[LFSR_LEN-1:1]});
   assign bad_s        = (Ran[0] != p_s) || (Ran[1] != q_s);
   assign seed_shift_s = {Ran[0], shreg_q[LFSR_LEN-1:1]};
   assign consec_inc_s = consec_q + 8'd1;
   assign err_cnt_d    = (err_cnt_q == ERR_MAX) ? err_cnt_q : err_cnt_q + ERR_ONE;

   // Seed/lock state machine with registered status outputs and error counter
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q     <= SEED;
         shreg_q     <= '0;
         seed_cnt_q  <= 4'd0;
         consec_q    <= 8'd0;
         err_cnt_q   <= '0;
         locked_q    <= 1'b0;
         error_q     <= 1'b0;
         lock_lost_q <= 1'b0;
      end else begin
         error_q     <= 1'b0;
         lock_lost_q <= 1'b0;
         if (Clear) begin
            err_cnt_q <= '0;
         end else if (En && (state_q == LOCKED) && bad_s) begin
            err_cnt_q <= err_cnt_d;
         end
         if (En) begin
            case (state_q)
               SEED: begin
                  shreg_q <= seed_shift_s;
                  if (seed_cnt_q == SEED_LAST) begin
                     seed_cnt_q <= 4'd0;
                     if (!is_lockup(seed_shift_s)) begin
                        state_q  <= LOCKED;
                        locked_q <= 1'b1;
                     end
                  end else begin
                     seed_cnt_q <= seed_cnt_q + 4'd1;
                  end
               end
               LOCKED: begin
                  // Feed back the prediction so a corrupted bit never pollutes r
                  shreg_q <= {p_s, shreg_q[LFSR_LEN-1:1]};
                  if (bad_s) begin
                     error_q <= 1'b1;
                     if (consec_inc_s == LOSS_LIM) begin
                        state_q     <= SEED;
                        locked_q    <= 1'b0;
                        lock_lost_q <= 1'b1;
                        seed_cnt_q  <= 4'd0;
                        consec_q    <= 8'd0;
                     end else begin
                        consec_q <= consec_inc_s;
                     end
                  end else begin
                     consec_q <= 8'd0;
                  end
               end
               default: begin
                  state_q  <= SEED;
                  locked_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign Locked   = locked_q;
   assign Error    = error_q;
   assign LockLost = lock_lost_q;
   assign ErrCount = err_cnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: directed table, hand-written corner sequences and a
// randomized run against a bit-level behavioural model of the checker rules.
module tb_prbs_checker;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        En;
   logic        Clear;
   logic [1:0]  Ran;
   logic        l1, e1, ll1;
   logic [15:0] c1;
   logic        l2, e2, ll2;
   logic [3:0]  c2;

   int checks   = 0;
   int failures = 0;
   int gn       = 0;
   bit seqb[$];

   typedef struct {
      int st;
      bit h[11];
      int seeded;
      int consec;
      int errcnt;
      bit error;
      bit lost;
   } model_t;

   typedef struct {
      bit       rst;
      bit       en;
      bit       clr;
      bit [1:0] inv;
      bit       locked;
      bit       error;
      bit       lost;
      int       cnt;
   } vec_t;

   model_t m1, m2;
   vec_t   tbl[35];

   always #5 Clock = ~Clock;

   prbs_checker #(.ERR_W(16), .LOSS_LIMIT(4)) dut1 (
      .Clock(Clock), .Reset(Reset), .En(En), .Ran(Ran), .Clear(Clear),
      .Locked(l1), .Error(e1), .LockLost(ll1), .ErrCount(c1)
   );

   prbs_checker #(.ERR_W(4), .LOSS_LIMIT(32)) dut2 (
      .Clock(Clock), .Reset(Reset), .En(En), .Ran(Ran), .Clear(Clear),
      .Locked(l2), .Error(e2), .LockLost(ll2), .ErrCount(c2)
   );

   // Generator stream b(n), extended on demand from b(n+11) = b(n) ^ ~b(n+2)
   function automatic bit gbit(input int i);
      while (seqb.size() <= i)
         seqb.push_back(seqb[seqb.size()-11] ^ ~seqb[seqb.size()-9]);
      return seqb[i];
   endfunction

   function automatic model_t mstep(input model_t m, input bit rst, input bit en,
                                    input bit clr, input bit [1:0] ran,
                                    input int errmax, input int limit);
      model_t n;
      bit p, q, nb;
      int ones;
      n = m; n.error = 1'b0; n.lost = 1'b0; p = 1'b0; q = 1'b0;
      if (rst) begin
         n.st = 0; n.seeded = 0; n.consec = 0; n.errcnt = 0;
         foreach (n.h[i]) n.h[i] = 1'b0;
         return n;
      end
      if (clr) n.errcnt = 0;
      if (en) begin
         if (m.st == 0) nb = ran[0];
         else begin
            p = m.h[0] ^ ~m.h[2];
            q = m.h[1] ^ ~m.h[3];
            nb = p;
         end
         for (int i = 0; i < 10; i++) n.h[i] = m.h[i+1];
         n.h[10] = nb;
         if (m.st == 0) begin
            n.seeded = m.seeded + 1;
            if (n.seeded == 11) begin
               n.seeded = 0;
               ones = 0;
               foreach (n.h[i]) ones += int'(n.h[i]);
               if (ones != 11) n.st = 1;
            end
         end else if (ran[0] != p || ran[1] != q) begin
            n.error = 1'b1;
            if (!clr && n.errcnt < errmax) n.errcnt++;
            n.consec = m.consec + 1;
            if (n.consec == limit) begin
               n.st = 0; n.seeded = 0; n.consec = 0; n.lost = 1'b1;
            end
         end else n.consec = 0;
      end
      return n;
   endfunction

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick_ran(input bit rst, input bit en, input bit clr, input bit [1:0] ran);
      Reset = rst; En = en; Clear = clr; Ran = ran;
      @(posedge Clock);
      m1 = mstep(m1, rst, en, clr, ran, 65535, 4);
      m2 = mstep(m2, rst, en, clr, ran, 15, 32);
      #1;
      chk("model_locked_w16", l1, m1.st);
      chk("model_error_w16", e1, m1.error);
      chk("model_lost_w16", ll1, m1.lost);
      chk("model_cnt_w16", c1, m1.errcnt);
      chk("model_locked_w4", l2, m2.st);
      chk("model_error_w4", e2, m2.error);
      chk("model_lost_w4", ll2, m2.lost);
      chk("model_cnt_w4", c2, m2.errcnt);
   endtask

   task automatic tick(input bit rst, input bit en, input bit clr, input bit [1:0] inv);
      bit [1:0] r;
      r = {gbit(gn+1), gbit(gn)} ^ inv;
      tick_ran(rst, en, clr, r);
      if (en) gn++;
   endtask

   initial begin
      int nen;
      bit en;
      for (int i = 0; i < 11; i++) seqb.push_back(1'($urandom_range(0, 1)));
      seqb[0] = 1'b0;

      // Directed table: lock, single error, loss of lock, relock, En=0, Clear
      for (int i = 0; i < 35; i++)
         tbl[i] = '{rst:1'b0, en:1'b1, clr:1'b0, inv:2'b00, locked:1'b0,
                    error:1'b0, lost:1'b0, cnt:0};
      tbl[0].rst = 1'b1;
      for (int i = 11; i <= 19; i++) tbl[i].locked = 1'b1;
      tbl[15].inv = 2'b01; tbl[15].error = 1'b1; tbl[15].cnt = 1;
      tbl[16].cnt = 1;
      for (int i = 17; i <= 20; i++) begin
         tbl[i].inv = 2'b01; tbl[i].error = 1'b1; tbl[i].cnt = i - 15;
      end
      tbl[20].lost = 1'b1;
      for (int i = 21; i <= 34; i++) tbl[i].cnt = 5;
      for (int i = 31; i <= 34; i++) tbl[i].locked = 1'b1;
      tbl[32].en = 1'b0; tbl[32].inv = 2'b11;
      tbl[33].clr = 1'b1; tbl[33].cnt = 0;
      tbl[34].en = 1'b0; tbl[34].cnt = 0;
      for (int i = 0; i < 35; i++) begin
         tick(tbl[i].rst, tbl[i].en, tbl[i].clr, tbl[i].inv);
         chk($sformatf("tbl%0d_locked", i), l1, tbl[i].locked);
         chk($sformatf("tbl%0d_error", i), e1, tbl[i].error);
         chk($sformatf("tbl%0d_lost", i), ll1, tbl[i].lost);
         chk($sformatf("tbl%0d_cnt", i), c1, tbl[i].cnt);
      end

      // Narrow counter saturates at 15; Clear beats a simultaneous increment
      tick(1'b1, 1'b1, 1'b0, 2'b00);
      for (int k = 1; k <= 11; k++) tick(1'b0, 1'b1, 1'b0, 2'b00);
      chk("w4_locked", l2, 1);
      for (int k = 1; k <= 20; k++) begin
         tick(1'b0, 1'b1, 1'b0, 2'b11);
         chk("w4_sat_cnt", c2, (k < 15) ? k : 15);
         chk("w4_sat_err", e2, 1);
      end
      chk("w4_still_locked", l2, 1);
      tick(1'b0, 1'b1, 1'b1, 2'b11);
      chk("w4_clear_cnt", c2, 0);
      chk("w4_clear_err", e2, 1);

      // Constant all-ones input is the lockup pattern and must never lock
      tick_ran(1'b1, 1'b1, 1'b0, 2'b11);
      for (int k = 0; k < 40; k++) begin
         tick_ran(1'b0, 1'b1, 1'b0, 2'b11);
         chk("ones_locked", l1, 0);
         chk("ones_cnt", c1, 0);
      end

      // Long clean run with En held high
      tick(1'b1, 1'b1, 1'b0, 2'b00);
      for (int c = 1; c <= 5000; c++) begin
         tick(1'b0, 1'b1, 1'b0, 2'b00);
         chk("run_locked", l1, (c >= 11) ? 1 : 0);
      end
      chk("run_cnt", c1, 0);

      // En toggling with the generator stepping only on enabled cycles
      tick(1'b1, 1'b1, 1'b0, 2'b00);
      nen = 0;
      for (int c = 0; c < 5000; c++) begin
         en = (c % 2 == 0);
         tick(1'b0, en, 1'b0, 2'b00);
         if (en) nen++;
         chk("toggle_locked", l1, (nen >= 11) ? 1 : 0);
         if (!en) chk("toggle_err_idle", e1, 0);
      end
      chk("toggle_cnt", c1, 0);

      // Reset while locked with a nonzero count, then relock after 11 samples
      tick(1'b0, 1'b1, 1'b0, 2'b01);
      chk("prerst_err", e1, 1);
      tick(1'b1, 1'b1, 1'b1, 2'b01);
      chk("rst_locked", l1, 0);
      chk("rst_error", e1, 0);
      chk("rst_lost", ll1, 0);
      chk("rst_cnt", c1, 0);
      for (int k = 1; k <= 11; k++) begin
         tick(1'b0, 1'b1, 1'b0, 2'b00);
         chk("relock", l1, (k == 11) ? 1 : 0);
      end

      // Randomized traffic against the model
      for (int c = 0; c < 3000; c++) begin
         tick(($urandom_range(0, 499) == 0), ($urandom_range(0, 3) != 0),
              ($urandom_range(0, 99) == 0),
              ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prbs_checker.md
PRBS_CHECKER -- requirements
Module: prbs_checker

Interface
REQ-001 Parameter ERR_W, default 16, width of the error counter.
REQ-002 Parameter LOSS_LIMIT, default 4, number of consecutive errored samples that drops lock (range 1..255).
REQ-003 Clock  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  synchronous, active-high reset.
REQ-005 En  input  1  sample qualifier; state advances only on cycles with En=1.
REQ-006 Ran  input  2  PRBS sample from the 11-bit XNOR-feedback generator: Ran[0] is bit b(n), Ran[1] is bit b(n+1).
REQ-007 Clear  input  1  synchronous clear of ErrCount.
REQ-008 Locked  output  1  high while in state LOCKED.
REQ-009 Error  output  1  one-cycle pulse per errored sample.
REQ-010 LockLost  output  1  one-cycle pulse on the LOCKED to SEED transition.
REQ-011 ErrCount  output  ERR_W  saturating count of errored samples.

Function
REQ-012 Sequence law: b(n+11) = b(n) XOR NOT b(n+2); all-ones 11-bit state is the generator lockup state and is never valid.
REQ-013 State machine: two states, SEED and LOCKED; no other states.
REQ-014 Shadow register r[10:0] holds 11 bits, r[10] newest, r[0] oldest.
REQ-015 SEED: each En cycle, r <= {Ran[0], r[10:1]} and seed counter increments; no error checking.
REQ-016 On the 11th seeding sample: go to LOCKED if the resulting r is not all-ones; otherwise stay in SEED with seed counter reset to 0.
REQ-017 LOCKED: predicted p = r[0] XOR NOT r[2], q = r[1] XOR NOT r[3]; a sample is errored if Ran[0] != p or Ran[1] != q.
REQ-018 LOCKED update: r <= {p, r[10:1]}, using the predicted bit and never the received bit, so one corrupted bit gives exactly one errored sample per affected Ran position.
REQ-019 Error, LockLost and Locked are registered: each asserts in the cycle after the clock edge that sampled the event.
REQ-020 Each errored sample in LOCKED increments ErrCount by 1; at 2^ERR_W-1 it holds (no wrap).
REQ-021 Consecutive-error counter: increments on an errored sample and clears on a good sample.
REQ-022 Loss of lock: when the consecutive-error count reaches LOSS_LIMIT, the error is counted, the state goes to SEED, the seed counter and consecutive counter clear, and LockLost pulses.
REQ-023 ErrCount is preserved across loss of lock.
REQ-024 Clear=1 sets ErrCount to 0 and takes priority over a simultaneous increment; it does not affect state or r.
REQ-025 En=0: no state, counter or r change, and Error and LockLost are 0 that cycle.

Reset
REQ-026 Reset=1 for one or more cycles, at any time including mid-seed or while LOCKED, sets:
- state SEED
- r, seed counter, consecutive counter and ErrCount to 0
- Locked, Error and LockLost to 0
REQ-027 Reset overrides En and Clear.

Structure
REQ-028 Shared package prbs_pkg holds LFSR_LEN=11, the tap positions (0,2), the SEED/LOCKED state typedef and the next-bit function.
REQ-029 Single flat module with no sub-module; the next-bit function is shared with the generator through prbs_pkg.

Verification
REQ-030 Generator driven from the same Clock, checker En=1, Reset released at cycle 0 -> Locked=1 from cycle 12 onward, ErrCount=0 after 5000 cycles.
REQ-031 After lock, invert Ran[0] for one sample -> exactly one Error pulse, ErrCount=1, Locked stays 1.
REQ-032 After lock, invert Ran[0] on 4 consecutive samples (LOSS_LIMIT=4) -> 4 Error pulses, LockLost pulses once, ErrCount=4, Locked=0, and Locked=1 again 11 En cycles later.
REQ-033 Ran=2'b11 constant for 40 cycles from reset -> Locked never asserts, ErrCount=0.
REQ-034 ERR_W=4, LOSS_LIMIT=32, after lock invert both Ran bits for 20 samples -> ErrCount reaches 15 and holds; Clear asserted together with an errored sample -> ErrCount=0 next cycle.
REQ-035 En toggled 1/0 every cycle with the generator clock-enabled in step -> same results as REQ-030; Reset pulsed while LOCKED -> all outputs 0 next cycle, re-lock after 11 En samples.
